// File: rtl/uart_tx_core_if.sv
// Purpose: request-side bundle between the TX request logic and the UART serializer.
// Latency: none, wires only.
// Backpressure: BUSY returns from the serializer; requests made while it is high are dropped unless the frame is in its stop bit.
// Signals: P_DATA payload, DATA_VALID one-cycle strobe, PAR_EN/PAR_TYP parity control, BUSY frame in progress.
`timescale 1ns/1ps
interface uart_tx_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  BUSY;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        input  BUSY
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        output BUSY
    );
endinterface

// File: rtl/uart_tx_core.sv
// Purpose: UART transmit serializer: start bit, LSB-first data, optional even/odd parity, one stop bit.
// Latency: start bit on TX_OUT right after the accepting edge; frame lasts DATA_WIDTH+2 cycles (+1 with parity).
// Backpressure: requests accepted only in IDLE or during the stop bit; anything else is dropped, never queued.
// Ports: CLK bit clock (one period = one bit), RST async active-low, bus request side (slave), TX_OUT serial line (idles 1).
`timescale 1ns/1ps
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_core_if.slave bus,
    output logic          TX_OUT
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] data_q;     // shifts right; bit 0 is the bit on the line
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  load;

    // The stop bit is the only mid-frame point where a new request is taken,
    // which is what gives back-to-back frames with no idle gap.
    assign load = bus.DATA_VALID && ((state == IDLE) || (state == STOP));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else if (load) begin
            state     <= START;
            bit_cnt   <= '0;
            data_q    <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                START: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    tx_q    <= data_q[0];
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (par_en_q) begin
                            state <= PARITY;
                            tx_q  <= par_bit_q;
                        end else begin
                            state <= STOP;
                            tx_q  <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        data_q  <= data_q >> 1;
                        tx_q    <= data_q[1];
                    end
                end
                PARITY: begin
                    state <= STOP;
                    tx_q  <= 1'b1;
                end
                STOP: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT   = tx_q;
    assign bus.BUSY = busy_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// Purpose: self-checking bench for uart_tx_core: directed frames plus randomized requests.
// Latency: a line-level receiver decodes each frame and compares it with the request the model recorded at its accepting edge.
// Backpressure: the model tracks frame occupancy arithmetically to decide which requests the serializer must accept.
`timescale 1ns/1ps
module tb_uart_tx_core;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        logic         pe;
        logic         pt;
    } frame_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic TX_OUT;

    uart_tx_core_if #(.DATA_WIDTH(W)) bus ();

    uart_tx_core #(.DATA_WIDTH(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .bus    (bus.slave),
        .TX_OUT (TX_OUT)
    );

    always #5 CLK = ~CLK;

    int     n_checks = 0;
    int     n_errors = 0;
    frame_t exp_q[$];
    int     m_rem = 0;   // cycles of the current frame still on the line, counting the present one

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is start + W data + optional parity + stop bits long.
    // A request is taken when the line is free or in its final (stop) bit.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_rem = 0;
            exp_q.delete();
        end else if (m_rem <= 1 && bus.DATA_VALID === 1'b1) begin
            exp_q.push_back('{bus.P_DATA, bus.PAR_EN, bus.PAR_TYP});
            m_rem = W + 2 + (bus.PAR_EN ? 1 : 0);
        end else if (m_rem > 0) begin
            m_rem--;
        end
    end

    // Line-level receiver, one sample per bit time.
    bit           rx_on = 1'b0;
    int           rx_pos = 0;
    frame_t       cur;
    logic [W-1:0] rx_data;

    always @(negedge CLK) begin
        if (!RST) begin
            rx_on = 1'b0;
            chk("reset_tx", 32'(TX_OUT), 32'd1);
            chk("reset_busy", 32'(bus.BUSY), 32'd0);
        end else begin
            chk("busy", 32'(bus.BUSY), 32'(m_rem > 0));
            if (!rx_on) begin
                chk("line_idle_or_start", 32'(TX_OUT), 32'(m_rem == 0));
                if (m_rem > 0) begin
                    chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        cur    = exp_q.pop_front();
                        rx_on  = 1'b1;
                        rx_pos = 0;
                    end
                end
            end else begin
                rx_pos++;
                if (rx_pos <= W) begin
                    rx_data[rx_pos-1] = TX_OUT;
                end else if (cur.pe && rx_pos == W + 1) begin
                    chk("parity_bit", 32'(TX_OUT), 32'((^cur.data) ^ cur.pt));
                end else begin
                    chk("stop_bit", 32'(TX_OUT), 32'd1);
                    chk("frame_data", 32'(rx_data), 32'(cur.data));
                    rx_on = 1'b0;
                end
            end
        end
    end

    // Expected line window for one frame starting at bit 0, idle ones afterwards.
    function automatic logic [63:0] frame_bits(input logic [W-1:0] d, input logic pe, input logic pt);
        logic [63:0] b;
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < W; i++) b[1+i] = d[i];
        if (pe) b[W+1] = (^d) ^ pt;
        return b;
    endfunction

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
        sync();
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.DATA_VALID = 1'b1;
        @(posedge CLK);
        #1 bus.DATA_VALID = 1'b0;
    endtask

    task automatic capture(input int n, output logic [63:0] bits, output int busy_cycles);
        bits        = '1;
        busy_cycles = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            bits[i] = TX_OUT;
            if (bus.BUSY === 1'b1) busy_cycles++;
        end
    endtask

    logic [63:0] b, e, f;
    int          bc;

    initial begin
        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        RST            = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;

        // Idle after reset: line high, never busy.
        capture(5, b, bc);
        chk("idle_line", 32'(b[4:0]), 32'h1f);
        chk("idle_busy", 32'(bc), 32'd0);

        // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1 then idle.
        send(8'hA5, 1'b0, 1'b0);
        capture(12, b, bc);
        chk("a5_sequence", 32'(b[11:0]), 32'h00000f4a);
        chk("a5_busy_cycles", 32'(bc), 32'd10);

        send(8'hA5, 1'b1, 1'b0);
        capture(13, b, bc);
        chk("a5_even_parity", 32'(b[9]), 32'd0);
        chk("a5_even_busy", 32'(bc), 32'd11);
        e = frame_bits(8'hA5, 1'b1, 1'b0);
        chk("a5_even_frame", 32'(b[12:0]), 32'(e[12:0]));

        send(8'hA5, 1'b1, 1'b1);
        capture(13, b, bc);
        chk("a5_odd_parity", 32'(b[9]), 32'd1);

        send(8'h07, 1'b1, 1'b0);
        capture(13, b, bc);
        chk("07_even_parity", 32'(b[9]), 32'd1);

        // Held DATA_VALID: 0x55 then 0xFF presented in the stop cycle.
        sync();
        bus.P_DATA     = 8'h55;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b1;
        fork
            begin
                repeat (10) @(posedge CLK);
                #1 bus.P_DATA = 8'hFF;
                @(posedge CLK);
                #1 bus.DATA_VALID = 1'b0;
            end
            capture(23, b, bc);
        join
        e = frame_bits(8'h55, 1'b0, 1'b0);
        f = frame_bits(8'hFF, 1'b0, 1'b0);
        e = {e[62:0], 1'b1};
        e[20:11] = f[9:0];
        chk("b2b_window", 32'(b[22:0]), 32'(e[22:0]));
        chk("b2b_second_start", 32'(b[11]), 32'd0);
        chk("b2b_busy_cycles", 32'(bc), 32'd20);

        // Request during data bit 3 must be dropped.
        fork
            begin
                send(8'hA5, 1'b0, 1'b0);
                fork
                    begin
                        repeat (4) @(posedge CLK);
                        #1 bus.P_DATA = 8'h3C;
                        bus.DATA_VALID = 1'b1;
                        @(posedge CLK);
                        #1 bus.DATA_VALID = 1'b0;
                    end
                    capture(14, b, bc);
                join
            end
        join
        e = frame_bits(8'hA5, 1'b0, 1'b0);
        chk("ignored_req_frame", 32'(b[13:0]), 32'(e[13:0]));
        chk("ignored_req_busy", 32'(bc), 32'd10);

        // Reset during data bit 4 aborts the frame at once.
        send(8'hC3, 1'b1, 1'b1);
        repeat (5) @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        chk("rst_async_tx", 32'(TX_OUT), 32'd1);
        chk("rst_async_busy", 32'(bus.BUSY), 32'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        capture(6, b, bc);
        chk("post_rst_idle", 32'(b[5:0]), 32'h3f);
        chk("post_rst_busy", 32'(bc), 32'd0);

        // Randomized requests, including long valid bursts that chain frames.
        for (int it = 0; it < 60; it++) begin
            int gap;
            int hold;
            gap  = $urandom_range(0, 12);
            hold = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                sync();
                bus.P_DATA  = W'($urandom);
                bus.PAR_EN  = 1'($urandom_range(0, 1));
                bus.PAR_TYP = 1'($urandom_range(0, 1));
            end
            for (int h = 0; h < hold; h++) begin
                sync();
                bus.P_DATA     = W'($urandom);
                bus.PAR_EN     = 1'($urandom_range(0, 1));
                bus.PAR_TYP    = 1'($urandom_range(0, 1));
                bus.DATA_VALID = 1'b1;
            end
            sync();
            bus.DATA_VALID = 1'b0;
        end

        // Drain with a bounded wait.
        for (int t = 0; t < 100 && (bus.BUSY !== 1'b0 || m_rem != 0); t++) @(posedge CLK);
        repeat (2) @(negedge CLK);
        chk("drain_idle", 32'(bus.BUSY), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rx_done", 32'(rx_on), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
